sad_accumulator: RTL
====================

SAD_ACCUMULATOR -- requirements
Module: sad_accumulator

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W, default 8: pixel width, unsigned.
REQ-003 Parameter BLOCK_N, default 16: pixel pairs per block; power of two, at least 2.
REQ-004 Parameter SAD_W, default DATA_W+$clog2(BLOCK_N): result width; a value below the default SHALL be rejected at elaboration.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port reset, input, 1: synchronous active-high reset.
REQ-007 Port in_valid, input, 1: A_data/B_data valid this cycle.
REQ-008 Port in_ready, output, 1: block can accept a pair.
REQ-009 Port A_data, input, DATA_W: current-block pixel.
REQ-010 Port B_data, input, DATA_W: reference-block pixel.
REQ-011 Port abort, input, 1: discard the block in progress.
REQ-012 Port sad_out, output, SAD_W: block SAD result.
REQ-013 Port out_valid, output, 1: sad_out valid.
REQ-014 Port out_ready, output-side consumer input, 1: result taken when out_valid is also high.
REQ-015 Port pair_count, output, $clog2(BLOCK_N): pairs accepted in the current block.

Function
REQ-016 A pair is accepted when in_valid and in_ready are both high on a clk edge.
REQ-017 The per-pair term SHALL be |A_data-B_data|, computed unsigned at DATA_W+1 bits, so it is exact for all inputs.
REQ-018 The FSM SHALL have two states. ACCUM drives in_ready=1 and out_valid=0. HOLD drives in_ready=0 and out_valid=1.
REQ-019 In ACCUM, each accepted pair SHALL add its term to the accumulator and increment pair_count.
REQ-020 When the accepted pair has pair_count==BLOCK_N-1, the next edge SHALL load sad_out with acc+term, clear acc and pair_count, and enter HOLD. Latency is 1 cycle from the last pair to out_valid.
REQ-021 HOLD SHALL keep sad_out stable until out_valid&&out_ready; the next edge returns to ACCUM.
REQ-022 No pair is accepted in the HOLD cycle where the result is consumed. Peak throughput is BLOCK_N pairs per BLOCK_N+1 cycles.
REQ-023 The accumulator SHALL never overflow: the maximum is BLOCK_N*(2^DATA_W-1), which fits SAD_W.
REQ-024 abort in ACCUM SHALL clear acc and pair_count next edge. A pair presented in the same cycle is discarded and in_ready stays 1.
REQ-025 abort in HOLD SHALL drop the result: out_valid=0 and state=ACCUM next edge, even if out_ready is high.
REQ-026 abort has priority over acceptance and over completion.
REQ-027 in_valid low SHALL stall accumulation with no state change. Gaps inside a block are legal.
REQ-028 sad_out SHALL change only on entry to HOLD or on reset.

Reset
REQ-029 The reset values SHALL be: state=ACCUM, acc=0, pair_count=0, sad_out=0, out_valid=0, in_ready=1 (first cycle after reset).
REQ-030 Reset mid-block or in HOLD SHALL discard all partial and pending results. Reset has priority over abort and over all handshakes.

Structure
REQ-031 The state encoding and the SAD_W width function SHALL reside in a shared package sad_pkg, for reuse by future SAD array blocks.
REQ-032 The combinational absolute-difference SHALL be a sub-module abs_diff, parametrised by DATA_W, producing a DATA_W-bit unsigned magnitude.
REQ-033 All state SHALL be in a single clocked process. No latches, and no combinational path from in_valid to in_ready.

Verification
REQ-034 Sixteen pairs A=10, B=3 back-to-back, out_ready=1: sad_out=112 with out_valid for 1 cycle, 1 cycle after the 16th pair.
REQ-035 Sixteen pairs A=3, B=10: sad_out=112, confirming the difference is absolute.
REQ-036 Sixteen pairs A=255, B=0: sad_out=4080 exactly with SAD_W=12, no wrap.
REQ-037 Block complete with out_ready=0 for 5 cycles: in_ready=0 and sad_out stable throughout; the next block is accepted only after the handshake.
REQ-038 Abort after 7 pairs, then 16 pairs A=1, B=0: sad_out=16 and pair_count restarts at 0.
REQ-039 Reset asserted after 9 pairs, or while in HOLD: all outputs at reset values next cycle, and no stale result is emitted afterward.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared definitions for sum-of-absolute-differences blocks: state encoding
// and the result-width function, so SAD arrays built later size identically.
package sad_pkg;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  // Narrowest result width that holds block_n * (2^data_w - 1) without wrap.
  function automatic int sad_width(input int data_w, input int block_n);
    return data_w + $clog2(block_n);
  endfunction

endpackage

// File: rtl/abs_diff.sv
// Combinational unsigned absolute difference |a - b|.
// The subtraction is done one bit wider so the sign is always visible,
// and the magnitude then always fits back into DATA_W bits.
module abs_diff #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] mag
);

  logic [DATA_W:0] diff;
  logic [DATA_W:0] neg_diff;

  // Wide difference; negate when the sign bit shows b > a.
  always_comb begin
    diff     = {1'b0, a} - {1'b0, b};
    neg_diff = '0 - diff;
    mag      = diff[DATA_W] ? neg_diff[DATA_W-1:0] : diff[DATA_W-1:0];
  end

endmodule

// File: rtl/sad_accumulator.sv
// Block SAD accumulator: sums |A-B| over BLOCK_N accepted pixel pairs, then
// holds the result until the consumer takes it. abort drops the current
// block (or pending result); reset drops everything.
module sad_accumulator
  import sad_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int BLOCK_N = 16,
  parameter int SAD_W   = sad_width(DATA_W, BLOCK_N)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          A_data,
  input  logic [DATA_W-1:0]          B_data,
  input  logic                       abort,
  output logic [SAD_W-1:0]           sad_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(BLOCK_N)-1:0] pair_count
);

  localparam int CNT_W = $clog2(BLOCK_N);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(BLOCK_N - 1);

  // A narrow result width would silently wrap, so refuse to build it.
  if (SAD_W < sad_width(DATA_W, BLOCK_N)) begin : g_bad_sad_w
    $error("sad_accumulator: SAD_W too small for DATA_W/BLOCK_N");
  end
  if (BLOCK_N < 2 || (BLOCK_N & (BLOCK_N - 1)) != 0) begin : g_bad_block_n
    $error("sad_accumulator: BLOCK_N must be a power of two >= 2");
  end

  logic [0:0]        state;
  logic [SAD_W-1:0]  acc;
  logic [DATA_W-1:0] term;
  logic [SAD_W-1:0]  sum;

  abs_diff #(.DATA_W(DATA_W)) u_abs_diff (
    .a   (A_data),
    .b   (B_data),
    .mag (term)
  );

  // Handshake outputs depend only on state, so in_valid never reaches in_ready.
  always_comb begin
    in_ready  = (state == ST_ACCUM);
    out_valid = (state == ST_HOLD);
    sum       = acc + SAD_W'(term);
  end

  // All state: reset first, then abort, then pair acceptance / result handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_ACCUM;
      acc        <= '0;
      pair_count <= '0;
      sad_out    <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (abort) begin
            acc        <= '0;
            pair_count <= '0;
          end else if (in_valid) begin
            if (pair_count == LAST_PAIR) begin
              sad_out    <= sum;
              acc        <= '0;
              pair_count <= '0;
              state      <= ST_HOLD;
            end else begin
              acc        <= sum;
              pair_count <= pair_count + 1'b1;
            end
          end
        end
        default: begin
          if (abort || out_ready) begin
            state <= ST_ACCUM;
          end
        end
      endcase
    end
  end

endmodule
